// File: rtl/fmul_arbiter_if.sv
// Requester-side bundle for fmul_arbiter: per-requester op handshake and result return.
// Operands are packed 32 bits per requester, requester i at [32i+31:32i].
interface fmul_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_x1;
  logic [NREQ*32-1:0]   req_x2;
  logic [NREQ-1:0]      res_valid;
  logic [31:0]          res_y;

  modport master (
    output req_valid, req_x1, req_x2,
    input  req_ready, res_valid, res_y
  );

  modport slave (
    input  req_valid, req_x1, req_x2,
    output req_ready, res_valid, res_y
  );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin share of one pipelined fmul; result returns 1+LAT cycles after the handshake.
// Only hold stalls issue; results are never backpressured and the tag pipe always shifts.
module fmul_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           hold,
  fmul_arbiter_if.slave  rq,
  output logic [31:0]    fm_x1,
  output logic [31:0]    fm_x2,
  input  logic [31:0]    fm_y,
  output logic           busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IDW-1:0] id_t;

  id_t                   rr_q, rr_d;
  logic [31:0]           fm_x1_q, fm_x1_d;
  logic [31:0]           fm_x2_q, fm_x2_d;
  logic [LAT:0]          tag_vld_q, tag_vld_d;
  logic [LAT:0][IDW-1:0] tag_id_q, tag_id_d;

  logic                  grant_vld;
  id_t                   grant_id;
  logic [IDW:0]          scan_sum;
  id_t                   scan_idx;

  // Scan from rr upward, wrapping modulo NREQ; the first pending requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int off = 0; off < NREQ; off++) begin
      scan_sum = {1'b0, rr_q} + (IDW+1)'(off);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_vld && rq.req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
    if (hold || rstn) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    rq.req_ready = '0;
    if (grant_vld) begin
      rq.req_ready[grant_id] = 1'b1;
    end
  end

  // A grant is only ever given to a valid requester, so grant_vld is the accept.
  always_comb begin
    rr_d    = rr_q;
    fm_x1_d = '0;
    fm_x2_d = '0;
    if (grant_vld) begin
      rr_d    = (grant_id == id_t'(NREQ-1)) ? '0 : grant_id + id_t'(1);
      fm_x1_d = rq.req_x1[{grant_id, 5'd0} +: 32];
      fm_x2_d = rq.req_x2[{grant_id, 5'd0} +: 32];
    end
    tag_vld_d = {tag_vld_q[LAT-1:0], grant_vld};
    tag_id_d  = {tag_id_q[LAT-1:0], grant_id};
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      rr_q      <= '0;
      fm_x1_q   <= '0;
      fm_x2_q   <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      fm_x1_q   <= fm_x1_d;
      fm_x2_q   <= fm_x2_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  assign fm_x1 = fm_x1_q;
  assign fm_x2 = fm_x2_q;

  // The last tag stage lines up with fm_y; ops flushed by reset never reach it.
  always_comb begin
    rq.res_valid = '0;
    if (tag_vld_q[LAT] && !rstn) begin
      rq.res_valid[tag_id_q[LAT]] = 1'b1;
    end
  end

  assign rq.res_y = fm_y;
  assign busy     = (|tag_vld_q) && !rstn;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed bench for fmul_arbiter with a 2-stage table-driven fmul stand-in.
module tb_fmul_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic        clk;
  logic        rstn;
  logic        hold;
  logic [31:0] fm_x1, fm_x2, fm_y;
  logic        busy;
  logic [31:0] mp0, mp1;
  int          n_checks;
  int          n_fail;

  fmul_arbiter_if #(.NREQ(NREQ)) rif ();

  fmul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .hold  (hold),
    .rq    (rif.slave),
    .fm_x1 (fm_x1),
    .fm_x2 (fm_x2),
    .fm_y  (fm_y),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed IEEE-754 single products for the operand pairs used below.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_3F800000: return 32'h3F800000;
      64'h40000000_40000000: return 32'h40800000;
      64'h40000000_40400000: return 32'h40C00000;
      64'h40400000_40400000: return 32'h41100000;
      64'h40800000_40800000: return 32'h41800000;
      64'h80000000_C0000000: return 32'h00000000;
      default:               return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    mp0 <= fmul_ref(fm_x1, fm_x2);
    mp1 <= mp0;
  end
  assign fm_y = mp1;

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    rif.req_x1[32*i +: 32] = a;
    rif.req_x2[32*i +: 32] = b;
  endtask

  task automatic do_reset;
    rstn = 1'b1;
    hold = 1'b0;
    rif.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    hold = 1'b0;
    rif.req_valid = 4'hF;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h3F800000, 32'h3F800000);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (rif.req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", rif.req_ready); end
    n_checks++;
    if (rif.res_valid !== 4'h0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0000", rif.res_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (fm_x1 !== 32'h0 || fm_x2 !== 32'h0) begin n_fail++; $display("FAIL reset_fm_x: got %h/%h expected 0/0", fm_x1, fm_x2); end
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rif.req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_rr_start: got %b expected 0001", rif.req_ready); end
    @(posedge clk);
    #1 rif.req_valid = '0;
  endtask

  task automatic test_single_op;
    logic [3:0] res_e;
    do_reset;
    set_op(2, 32'h40000000, 32'h40400000);
    for (int c = 0; c < 6; c++) begin
      rif.req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      res_e = (c == 3) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      n_checks++;
      if (rif.req_ready !== rif.req_valid) begin n_fail++; $display("FAIL single_ready c%0d: got %b expected %b", c, rif.req_ready, rif.req_valid); end
      n_checks++;
      if (rif.res_valid !== res_e) begin n_fail++; $display("FAIL single_res_valid c%0d: got %b expected %b", c, rif.res_valid, res_e); end
      n_checks++;
      if (busy !== (c >= 1 && c <= 3)) begin n_fail++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy, (c >= 1 && c <= 3)); end
      if (c == 1) begin
        n_checks++;
        if (fm_x1 !== 32'h40000000 || fm_x2 !== 32'h40400000) begin n_fail++; $display("FAIL single_fm_x: got %h/%h expected 40000000/40400000", fm_x1, fm_x2); end
      end
      if (c == 2) begin
        n_checks++;
        if (fm_x1 !== 32'h0) begin n_fail++; $display("FAIL single_fm_x_idle: got %h expected 00000000", fm_x1); end
      end
      if (c == 3) begin
        n_checks++;
        if (rif.res_y !== 32'h40C00000) begin n_fail++; $display("FAIL single_res_y: got %h expected 40C00000", rif.res_y); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_contention;
    logic [31:0] pa [4] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000};
    logic [31:0] pb [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40400000};
    logic [31:0] pe [4] = '{32'h3F800000, 32'h40800000, 32'h40C00000, 32'h41100000};
    logic [3:0]  rdy_e, res_e;
    int          rid;
    do_reset;
    for (int i = 0; i < NREQ; i++) set_op(i, pa[i], pb[i]);
    for (int c = 0; c < 9; c++) begin
      rif.req_valid = (c <= 4) ? 4'hF : 4'h0;
      rdy_e = (c <= 4) ? 4'(1 << (c % 4)) : 4'h0;
      rid = (c - 3) % 4;
      res_e = (c >= 3 && c <= 7) ? 4'(1 << rid) : 4'h0;
      @(negedge clk);
      n_checks++;
      if (rif.req_ready !== rdy_e) begin n_fail++; $display("FAIL contention_ready c%0d: got %b expected %b", c, rif.req_ready, rdy_e); end
      n_checks++;
      if (rif.res_valid !== res_e) begin n_fail++; $display("FAIL contention_res_valid c%0d: got %b expected %b", c, rif.res_valid, res_e); end
      if (res_e != 4'h0) begin
        n_checks++;
        if (rif.res_y !== pe[rid]) begin n_fail++; $display("FAIL contention_res_y c%0d: got %h expected %h", c, rif.res_y, pe[rid]); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wrap;
    logic [3:0]  rdy_e, res_e;
    logic [31:0] y_e;
    do_reset;
    set_op(1, 32'h40800000, 32'h40800000);
    set_op(3, 32'h40400000, 32'h40400000);
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(2, 32'h3F800000, 32'h3F800000);
    for (int c = 0; c < 8; c++) begin
      rif.req_valid = (c <= 3) ? 4'b1010 : 4'b0000;
      rdy_e = (c <= 3) ? (((c % 2) == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
      res_e = (c >= 3 && c <= 6) ? ((((c - 3) % 2) == 0) ? 4'b0010 : 4'b1000) : 4'b0000;
      y_e   = (res_e == 4'b0010) ? 32'h41800000 : 32'h41100000;
      @(negedge clk);
      n_checks++;
      if (rif.req_ready !== rdy_e) begin n_fail++; $display("FAIL wrap_ready c%0d: got %b expected %b", c, rif.req_ready, rdy_e); end
      n_checks++;
      if ((rif.req_ready & ~rif.req_valid) !== 4'b0000) begin n_fail++; $display("FAIL wrap_invalid_grant c%0d: got %b expected 0000", c, rif.req_ready & ~rif.req_valid); end
      n_checks++;
      if (rif.res_valid !== res_e) begin n_fail++; $display("FAIL wrap_res_valid c%0d: got %b expected %b", c, rif.res_valid, res_e); end
      if (res_e != 4'h0) begin
        n_checks++;
        if (rif.res_y !== y_e) begin n_fail++; $display("FAIL wrap_res_y c%0d: got %h expected %h", c, rif.res_y, y_e); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_hold;
    logic [3:0]  vt   [9] = '{4'b0001, 4'b0100, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    logic        ht   [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0]  rdy  [9] = '{4'b0001, 4'b0100, 4'h0, 4'h0, 4'h0, 4'b1000, 4'h0, 4'h0, 4'h0};
    logic [3:0]  res  [9] = '{4'h0, 4'h0, 4'h0, 4'b0001, 4'b0100, 4'h0, 4'h0, 4'h0, 4'b1000};
    logic        bz   [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] pe   [4] = '{32'h3F800000, 32'h0, 32'h40C00000, 32'h41100000};
    logic [31:0] y_e;
    do_reset;
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(1, 32'h3F800000, 32'h3F800000);
    set_op(2, 32'h40000000, 32'h40400000);
    set_op(3, 32'h40400000, 32'h40400000);
    for (int c = 0; c < 9; c++) begin
      rif.req_valid = vt[c];
      hold = ht[c];
      y_e = (res[c] == 4'b0001) ? pe[0] : (res[c] == 4'b0100) ? pe[2] : pe[3];
      @(negedge clk);
      n_checks++;
      if (rif.req_ready !== rdy[c]) begin n_fail++; $display("FAIL hold_ready c%0d: got %b expected %b", c, rif.req_ready, rdy[c]); end
      n_checks++;
      if (rif.res_valid !== res[c]) begin n_fail++; $display("FAIL hold_res_valid c%0d: got %b expected %b", c, rif.res_valid, res[c]); end
      n_checks++;
      if (busy !== bz[c]) begin n_fail++; $display("FAIL hold_busy c%0d: got %b expected %b", c, busy, bz[c]); end
      if (res[c] != 4'h0) begin
        n_checks++;
        if (rif.res_y !== y_e) begin n_fail++; $display("FAIL hold_res_y c%0d: got %h expected %h", c, rif.res_y, y_e); end
      end
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_midflight;
    logic [3:0] res_e;
    do_reset;
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(1, 32'h40000000, 32'h40000000);
    set_op(2, 32'h40000000, 32'h40400000);
    for (int c = 0; c < 3; c++) begin
      rif.req_valid = 4'b0111;
      @(negedge clk);
      n_checks++;
      if (rif.req_ready !== 4'(1 << c)) begin n_fail++; $display("FAIL midflight_issue c%0d: got %b expected %b", c, rif.req_ready, 4'(1 << c)); end
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
    rif.req_valid = 4'h0;
    @(negedge clk);
    n_checks++;
    if (rif.res_valid !== 4'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL midflight_in_reset: got res_valid=%b busy=%b expected 0000/0", rif.res_valid, busy); end
    @(posedge clk);
    #1 rstn = 1'b0;
    for (int c = 4; c < 9; c++) begin
      rif.req_valid = (c == 4) ? 4'hF : 4'h0;
      res_e = (c == 7) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      if (c == 4) begin
        n_checks++;
        if (rif.req_ready !== 4'b0001) begin n_fail++; $display("FAIL midflight_rr: got %b expected 0001", rif.req_ready); end
        n_checks++;
        if (busy !== 1'b0 || fm_x1 !== 32'h0) begin n_fail++; $display("FAIL midflight_flushed: got busy=%b fm_x1=%h expected 0/00000000", busy, fm_x1); end
      end
      n_checks++;
      if (rif.res_valid !== res_e) begin n_fail++; $display("FAIL midflight_res_valid c%0d: got %b expected %b", c, rif.res_valid, res_e); end
      if (c == 7) begin
        n_checks++;
        if (rif.res_y !== 32'h3F800000) begin n_fail++; $display("FAIL midflight_res_y: got %h expected 3F800000", rif.res_y); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_signed_zero;
    do_reset;
    set_op(1, 32'h80000000, 32'hC0000000);
    for (int c = 0; c < 5; c++) begin
      rif.req_valid = (c == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if (fm_x1 !== 32'h80000000 || fm_x2 !== 32'hC0000000) begin n_fail++; $display("FAIL szero_fm_x: got %h/%h expected 80000000/C0000000", fm_x1, fm_x2); end
      end
      n_checks++;
      if (rif.res_valid !== ((c == 3) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL szero_res_valid c%0d: got %b expected %b", c, rif.res_valid, (c == 3) ? 4'b0010 : 4'b0000); end
      if (c == 3) begin
        n_checks++;
        if (rif.res_y !== 32'h00000000) begin n_fail++; $display("FAIL szero_res_y: got %h expected 00000000", rif.res_y); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn = 1'b1;
    hold = 1'b0;
    rif.req_valid = '0;
    rif.req_x1 = '0;
    rif.req_x2 = '0;
    test_reset;
    test_single_op;
    test_contention;
    test_wrap;
    test_hold;
    test_reset_midflight;
    test_signed_zero;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
